mem_access: RTL and testbench

- Pipeline stage directly downstream of EX in the MIPS core.
- Takes the EX ALU result (effective address for memory ops) and the store data (Rdata2), and performs byte, halfword and word loads/stores over a single-outstanding req/ack data-memory bus.
- Loads are sign- or zero-extended. Non-memory instructions pass through with their Result.
- Produces one registered result per accepted instruction for writeback, flagging misaligned accesses and bus timeouts.

---
 rtl/mem_access_pkg.sv | 71 +++++++
 rtl/mem_access_load_align.sv | 26 ++
 rtl/mem_access.sv | 135 +++++++++++++
 tb/tb_mem_access.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared opcode constants, FSM state type and access-decode helpers for the MEM stage.
package mem_access_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } acc_size_t;

    function automatic acc_size_t op_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_size = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: op_size = SZ_HALF;
            OP_LW, OP_SW:         op_size = SZ_WORD;
            default:              op_size = SZ_NONE;
        endcase
    endfunction

    function automatic logic is_mem_op(input logic [5:0] op);
        is_mem_op = (op_size(op) != SZ_NONE);
    endfunction

    function automatic logic is_load_op(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: is_load_op = 1'b1;
            default:                             is_load_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] lane);
        case (op_size(op))
            SZ_HALF: is_misaligned = lane[0];
            SZ_WORD: is_misaligned = (lane != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [5:0] op, input logic [1:0] lane);
        case (op_size(op))
            SZ_BYTE: byte_enables = 4'b0001 << lane;
            SZ_HALF: byte_enables = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: byte_enables = 4'b1111;
            default: byte_enables = 4'b0000;
        endcase
    endfunction

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    function automatic logic [31:0] store_data(input logic [5:0] op, input logic [31:0] rdata2);
        case (op_size(op))
            SZ_BYTE: store_data = {4{rdata2[7:0]}};
            SZ_HALF: store_data = {2{rdata2[15:0]}};
            default: store_data = rdata2;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Selects the addressed byte/halfword of a little-endian read word and sign/zero-extends it.
module load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [5:0]  opcode,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[8*addr +: 8];
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        case (opcode)
            OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  data = {24'h0, byte_sel};
            OP_LH:   data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  data = {16'h0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: byte/half/word loads and stores over a single-outstanding req/ack bus.
// state | meaning
// IDLE  | ready for an instruction; non-memory and misaligned ops retire from here
// BUSY  | bus request outstanding, waiting for mem_ack or timeout
module mem_access
    import mem_access_pkg::*;
#(
    parameter  int TIMEOUT = 16,
    localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] Ins,
    input  logic [31:0] Result,
    input  logic [31:0] Rdata2,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [31:0] out_ins,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   wait_cnt;
    logic [31:0]        ins_q;
    logic [31:0]        result_q;
    logic [31:0]        load_data;
    logic [5:0]         in_op;
    logic               accept, mem_start, ack_done, abort;

    assign in_op    = Ins[31:26];
    assign in_ready = (state == IDLE) && !RST;

    load_align u_load_align (
        .rdata  (mem_rdata),
        .addr   (result_q[1:0]),
        .opcode (ins_q[31:26]),
        .data   (load_data)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        mem_start = 1'b0;
        ack_done  = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept = 1'b1;
                    if (is_mem_op(in_op) && !is_misaligned(in_op, Result[1:0])) begin
                        mem_start = 1'b1;
                        state_nx  = BUSY;
                    end
                end
            end
            BUSY: begin
                // An ack on the last counted cycle still completes the access.
                if (mem_ack) begin
                    ack_done = 1'b1;
                    state_nx = IDLE;
                end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    abort    = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ins   <= '0;
            err       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            wait_cnt  <= '0;
            ins_q     <= '0;
            result_q  <= '0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                ins_q    <= Ins;
                result_q <= Result;
                wait_cnt <= '0;
                if (mem_start) begin
                    mem_req   <= 1'b1;
                    mem_we    <= !is_load_op(in_op);
                    mem_addr  <= {Result[31:2], 2'b00};
                    mem_be    <= byte_enables(in_op, Result[1:0]);
                    mem_wdata <= store_data(in_op, Rdata2);
                end else begin
                    out_valid <= 1'b1;
                    out_ins   <= Ins;
                    err       <= is_mem_op(in_op);
                    out_data  <= is_mem_op(in_op) ? 32'h0 : Result;
                end
            end
            if (ack_done) begin
                mem_req   <= 1'b0;
                out_valid <= 1'b1;
                out_ins   <= ins_q;
                err       <= 1'b0;
                out_data  <= is_load_op(ins_q[31:26]) ? load_data : result_q;
            end else if (abort) begin
                mem_req   <= 1'b0;
                out_valid <= 1'b1;
                out_ins   <= ins_q;
                err       <= 1'b1;
                out_data  <= '0;
            end else if (state == BUSY) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Randomized self-checking bench for mem_access against a behavioural access model.
module tb_mem_access;

    localparam int TIMEOUT = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] Ins = '0;
    logic [31:0] Result = '0;
    logic [31:0] Rdata2 = '0;
    logic        out_valid;
    logic [31:0] out_data;
    logic [31:0] out_ins;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    mem_access #(.TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .Ins(Ins), .Result(Result), .Rdata2(Rdata2),
        .out_valid(out_valid), .out_data(out_data), .out_ins(out_ins), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: access size in bytes (0 = not a memory op)
    function automatic int mdl_size(input logic [5:0] op);
        case (op)
            6'h20, 6'h24, 6'h28: return 1;
            6'h21, 6'h25, 6'h29: return 2;
            6'h23, 6'h2B:        return 4;
            default:             return 0;
        endcase
    endfunction

    function automatic bit mdl_load(input logic [5:0] op);
        return (op == 6'h20 || op == 6'h21 || op == 6'h23 || op == 6'h24 || op == 6'h25);
    endfunction

    function automatic bit mdl_signed(input logic [5:0] op);
        return (op == 6'h20 || op == 6'h21);
    endfunction

    function automatic logic [3:0] mdl_be(input int size, input int lane);
        int v;
        v = ((1 << size) - 1) << lane;
        return v[3:0];
    endfunction

    function automatic logic [31:0] mdl_wdata(input int size, input logic [31:0] d);
        if (size == 1) return {24'h0, d[7:0]} * 32'h0101_0101;
        if (size == 2) return {16'h0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] mdl_load_val(input logic [5:0] op, input int lane,
                                                 input logic [31:0] rd);
        longint v, bits;
        int size;
        size = mdl_size(op);
        bits = 8 * size;
        v = longint'(rd >> (8 * lane)) & ((64'd1 << bits) - 1);
        if (mdl_signed(op) && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
        return v[31:0];
    endfunction

    // Issues one instruction; ack_delay = wait cycles before mem_ack, negative = never ack
    task automatic do_op(input string tag, input logic [5:0] op, input logic [31:0] res,
                         input logic [31:0] d2, input int ack_delay, input logic [31:0] rd);
        logic [31:0] ins, exp_data;
        int size, lane, n;
        bit mis;
        ins  = {op, 26'($urandom)};
        size = mdl_size(op);
        lane = int'(res[1:0]);
        mis  = (size != 0) && ((lane % size) != 0);

        @(negedge CLK);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; Ins = ins; Result = res; Rdata2 = d2;
        @(negedge CLK);
        in_valid = 1'b0; Ins = $urandom; Result = $urandom; Rdata2 = $urandom;

        if (size == 0 || mis) begin
            chk({tag, ".req"}, 32'(mem_req), 32'd0);
            chk({tag, ".ov"}, 32'(out_valid), 32'd1);
            chk({tag, ".err"}, 32'(err), 32'(mis));
            chk({tag, ".data"}, out_data, mis ? 32'h0 : res);
            exp_data = mis ? 32'h0 : res;
        end else begin
            chk({tag, ".req"}, 32'(mem_req), 32'd1);
            chk({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
            chk({tag, ".addr"}, mem_addr, res & 32'hFFFF_FFFC);
            chk({tag, ".we"}, 32'(mem_we), 32'(!mdl_load(op)));
            chk({tag, ".be"}, 32'(mem_be), 32'(mdl_be(size, lane)));
            if (!mdl_load(op)) chk({tag, ".wdata"}, mem_wdata, mdl_wdata(size, d2));
            if (ack_delay < 0) begin
                n = 0;
                while (mem_req === 1'b1 && n < 3 * TIMEOUT) begin
                    n++;
                    @(negedge CLK);
                end
                chk({tag, ".req_cycles"}, 32'(n), 32'(TIMEOUT));
                chk({tag, ".to_ov"}, 32'(out_valid), 32'd1);
                chk({tag, ".to_err"}, 32'(err), 32'd1);
                chk({tag, ".to_data"}, out_data, 32'h0);
                exp_data = 32'h0;
            end else begin
                for (int i = 0; i < ack_delay; i++) begin
                    chk({tag, ".req_held"}, 32'(mem_req), 32'd1);
                    chk({tag, ".ov_wait"}, 32'(out_valid), 32'd0);
                    @(negedge CLK);
                end
                mem_ack = 1'b1; mem_rdata = rd;
                @(negedge CLK);
                mem_ack = 1'b0; mem_rdata = $urandom;
                exp_data = mdl_load(op) ? mdl_load_val(op, lane, rd) : res;
                chk({tag, ".req_drop"}, 32'(mem_req), 32'd0);
                chk({tag, ".ov"}, 32'(out_valid), 32'd1);
                chk({tag, ".err"}, 32'(err), 32'd0);
                chk({tag, ".data"}, out_data, exp_data);
            end
        end
        chk({tag, ".ins"}, out_ins, ins);
        @(negedge CLK);
        chk({tag, ".pulse"}, 32'(out_valid), 32'd0);
        chk({tag, ".hold"}, out_data, exp_data);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops [9];
        ops = '{6'h00, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};

        repeat (2) @(negedge CLK);
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        chk("rst.ov", 32'(out_valid), 32'd0);
        chk("rst.req", 32'(mem_req), 32'd0);
        chk("rst.data", out_data, 32'h0);
        chk("rst.be", 32'(mem_be), 32'h0);
        chk("rst.addr", mem_addr, 32'h0);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst.in_ready_rel", 32'(in_ready), 32'd1);

        // Back-to-back ADDU, one result per cycle
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; Ins = 32'h0000_0021 | (32'(i) << 11); Result = 32'h0000_1234;
            @(negedge CLK);
            chk("b2b.in_ready", 32'(in_ready), 32'd1);
            chk("b2b.ov", 32'(out_valid), 32'd1);
            chk("b2b.data", out_data, 32'h0000_1234);
            chk("b2b.err", 32'(err), 32'd0);
            chk("b2b.req", 32'(mem_req), 32'd0);
        end
        in_valid = 1'b0;
        @(negedge CLK);
        chk("b2b.end", 32'(out_valid), 32'd0);

        // Stray ack in IDLE
        mem_ack = 1'b1;
        @(negedge CLK);
        mem_ack = 1'b0;
        chk("idle_ack.ov", 32'(out_valid), 32'd0);
        chk("idle_ack.ready", 32'(in_ready), 32'd1);

        do_op("sb0", 6'h28, 32'h100, 32'hAABB_CC85, 0, 32'h0);
        do_op("sb3", 6'h28, 32'h103, 32'hAABB_CC85, 0, 32'h0);
        do_op("lb", 6'h20, 32'h201, 32'h0, 3, 32'h1122_80FF);
        do_op("lbu", 6'h24, 32'h201, 32'h0, 3, 32'h1122_80FF);
        do_op("lhu", 6'h25, 32'h202, 32'h0, 1, 32'h1122_80FF);
        do_op("lh", 6'h21, 32'h202, 32'h0, 0, 32'h8001_0000);
        do_op("lw_mis", 6'h23, 32'h302, 32'h0, 0, 32'h0);
        do_op("sh_mis", 6'h29, 32'h305, 32'h0, 0, 32'h0);
        do_op("lw_to", 6'h23, 32'h400, 32'h0, -1, 32'h0);
        do_op("lw_last", 6'h23, 32'h400, 32'h0, TIMEOUT - 1, 32'hDEAD_BEEF);
        do_op("sw", 6'h2B, 32'h504, 32'h1234_5678, 2, 32'h0);

        // Async reset in the middle of a bus access
        @(negedge CLK);
        in_valid = 1'b1; Ins = {6'h23, 26'h0}; Result = 32'h600;
        @(negedge CLK);
        in_valid = 1'b0;
        chk("rstmid.req_before", 32'(mem_req), 32'd1);
        repeat (2) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("rstmid.req_drop", 32'(mem_req), 32'd0);
        chk("rstmid.in_ready", 32'(in_ready), 32'd0);
        repeat (2) begin
            @(negedge CLK);
            chk("rstmid.no_ov", 32'(out_valid), 32'd0);
        end
        RST = 1'b0;
        @(negedge CLK);
        chk("rstmid.no_ov_after", 32'(out_valid), 32'd0);
        chk("rstmid.ready", 32'(in_ready), 32'd1);
        do_op("post_rst_addu", 6'h00, 32'hCAFE_0001, 32'h0, 0, 32'h0);

        // Randomized mix
        for (int k = 0; k < 80; k++) begin
            logic [5:0] op;
            logic [31:0] res;
            int dly;
            op  = ops[$urandom_range(0, 8)];
            res = $urandom;
            if ($urandom_range(0, 3) == 0) res[1:0] = 2'b00;
            dly = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 6));
            do_op("rnd", op, res, $urandom, dly, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
